// File: rtl/contador_regressivo_mmss_if.sv
// Keypad/timebase/display bundle between the oven control side and the mm:ss countdown.
// The master drives the keypad strobe, digit, timebase and enable; the slave returns the display and flags.
interface contador_regressivo_mmss_if;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;
    logic       count_en;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       zero;
    logic       done;

    modport master (
        output D, loadn, pgt_1Hz, count_en,
        input  sec_ones, sec_tens, min_ones, min_tens, zero, done
    );

    modport slave (
        input  D, loadn, pgt_1Hz, count_en,
        output sec_ones, sec_tens, min_ones, min_tens, zero, done
    );
endinterface

// File: rtl/contador_regressivo_mmss.sv
// mm:ss BCD countdown with keypad shift-in entry and a 1 Hz decrement.
// Optional macro DONE_PULSE_EN adds a registered one-cycle pulse when a decrement reaches 00:00.
module contador_regressivo_mmss #(
    parameter int SEC_TENS_MAX = 5,
    parameter int MIN_TENS_MAX = 9
) (
    input  logic                         clk100,
    input  logic                         rst,
    contador_regressivo_mmss_if.slave    bus
);

    localparam logic [3:0] SEC_TENS_WRAP = 4'(SEC_TENS_MAX);
    localparam logic [3:0] MIN_TENS_SAT  = 4'(MIN_TENS_MAX);

    logic [3:0] sec_ones_p0, sec_tens_p0, min_ones_p0, min_tens_p0;
    logic       loadn_q, tick_q;
    logic       load_ev, tick_ev, do_shift, do_dec, is_zero;
    logic       borrow_so, borrow_st, borrow_mo;
    logic [3:0] dec_so, dec_st, dec_mo, dec_mt;

    function automatic logic [3:0] sat_min_tens(input logic [3:0] v);
        return (v > MIN_TENS_SAT) ? MIN_TENS_SAT : v;
    endfunction

    always_comb begin
        is_zero  = (sec_ones_p0 == 4'd0) && (sec_tens_p0 == 4'd0) &&
                   (min_ones_p0 == 4'd0) && (min_tens_p0 == 4'd0);
        load_ev  = loadn_q && !bus.loadn;
        tick_ev  = !tick_q && bus.pgt_1Hz;
        // A load in programming mode wins; while counting, loads are dropped and ticks run.
        do_shift = load_ev && !bus.count_en && (bus.D <= 4'd9);
        do_dec   = !(load_ev && !bus.count_en) && tick_ev && bus.count_en && !is_zero;

        borrow_so = (sec_ones_p0 == 4'd0);
        borrow_st = borrow_so && (sec_tens_p0 == 4'd0);
        borrow_mo = borrow_st && (min_ones_p0 == 4'd0);

        dec_so = borrow_so ? 4'd9 : sec_ones_p0 - 4'd1;
        dec_st = !borrow_so ? sec_tens_p0 :
                 (sec_tens_p0 == 4'd0) ? SEC_TENS_WRAP : sec_tens_p0 - 4'd1;
        dec_mo = !borrow_st ? min_ones_p0 :
                 (min_ones_p0 == 4'd0) ? 4'd9 : min_ones_p0 - 4'd1;
        dec_mt = borrow_mo ? min_tens_p0 - 4'd1 : min_tens_p0;
    end

    // Stage p0: digit registers and edge-detect history
    always_ff @(posedge clk100) begin
        if (rst) begin
            sec_ones_p0 <= 4'd0;
            sec_tens_p0 <= 4'd0;
            min_ones_p0 <= 4'd0;
            min_tens_p0 <= 4'd0;
            loadn_q     <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            loadn_q <= bus.loadn;
            tick_q  <= bus.pgt_1Hz;
            if (do_shift) begin
                min_tens_p0 <= sat_min_tens(min_ones_p0);
                min_ones_p0 <= sec_tens_p0;
                sec_tens_p0 <= sec_ones_p0;
                sec_ones_p0 <= bus.D;
            end else if (do_dec) begin
                min_tens_p0 <= dec_mt;
                min_ones_p0 <= dec_mo;
                sec_tens_p0 <= dec_st;
                sec_ones_p0 <= dec_so;
            end
        end
    end

`ifdef DONE_PULSE_EN
    logic done_p0;
    logic dec_to_zero;

    assign dec_to_zero = do_dec && (dec_so == 4'd0) && (dec_st == 4'd0) &&
                         (dec_mo == 4'd0) && (dec_mt == 4'd0);

    always_ff @(posedge clk100) begin
        if (rst) done_p0 <= 1'b0;
        else     done_p0 <= dec_to_zero;
    end

    assign bus.done = done_p0;
`else
    assign bus.done = 1'b0;
`endif

    assign bus.sec_ones = sec_ones_p0;
    assign bus.sec_tens = sec_tens_p0;
    assign bus.min_ones = min_ones_p0;
    assign bus.min_tens = min_tens_p0;
    assign bus.zero     = is_zero;

endmodule

// File: tb/tb_contador_regressivo_mmss.sv
// Scoreboard bench for the mm:ss countdown: a digit-array model predicts every cycle's outputs.
// Builds with or without DONE_PULSE_EN; the expected done behaviour follows the same macro.
module tb_contador_regressivo_mmss;

    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_TENS_MAX = 9;

    logic clk100 = 1'b0;
    logic rst;
    always #5 clk100 = ~clk100;

    contador_regressivo_mmss_if bus ();

    contador_regressivo_mmss #(
        .SEC_TENS_MAX (SEC_TENS_MAX),
        .MIN_TENS_MAX (MIN_TENS_MAX)
    ) dut (
        .clk100 (clk100),
        .rst    (rst),
        .bus    (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          done_seen;
    logic [17:0] sb[$];
    int          m[4];
    logic        m_ld_q, m_tk_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_zero();
        return (m[0] == 0) && (m[1] == 0) && (m[2] == 0) && (m[3] == 0);
    endfunction

    function automatic logic [15:0] disp();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic step(input logic r, input logic ld, input logic [3:0] d,
                        input logic p, input logic en);
        logic        lev, tev, dn;
        logic [17:0] e, g;
        @(negedge clk100);
        rst = r; bus.loadn = ld; bus.D = d; bus.pgt_1Hz = p; bus.count_en = en;
        dn = 1'b0;
        if (r) begin
            for (int i = 0; i < 4; i++) m[i] = 0;
            m_ld_q = 1'b1;
            m_tk_q = 1'b0;
        end else begin
            lev = m_ld_q && !ld;
            tev = !m_tk_q && p;
            m_ld_q = ld;
            m_tk_q = p;
            if (lev && !en) begin
                if (d <= 4'd9) begin
                    m[3] = (m[2] > MIN_TENS_MAX) ? MIN_TENS_MAX : m[2];
                    m[2] = m[1];
                    m[1] = m[0];
                    m[0] = int'(d);
                end
            end else if (tev && en && !m_zero()) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i] > 0) begin
                        m[i] = m[i] - 1;
                        break;
                    end
                    m[i] = (i == 1) ? SEC_TENS_MAX : 9;
                end
`ifdef DONE_PULSE_EN
                dn = m_zero();
`endif
            end
        end
        e = {4'(m[3]), 4'(m[2]), 4'(m[1]), 4'(m[0]), m_zero(), dn};
        sb.push_back(e);
        @(posedge clk100);
        #1;
        g = {disp(), bus.zero, bus.done};
        if (bus.done) done_seen++;
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else                check("cycle", 32'(g), 32'(sb.pop_front()));
    endtask

    task automatic press(input logic [3:0] d, input int hold, input logic en);
        for (int i = 0; i < hold; i++) step(1'b0, 1'b0, d, 1'b0, en);
        for (int i = 0; i < 2; i++)    step(1'b0, 1'b1, d, 1'b0, en);
    endtask

    task automatic load4(input logic [3:0] a, b, c, d);
        press(a, 3, 1'b0); press(b, 3, 1'b0); press(c, 3, 1'b0); press(d, 3, 1'b0);
    endtask

    task automatic tick(input logic en);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'd0, 1'b1, en);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'd0, 1'b0, en);
    endtask

    initial begin
        rst = 1'b1;
        bus.loadn = 1'b1; bus.D = 4'd0; bus.pgt_1Hz = 1'b0; bus.count_en = 1'b0;
        done_seen = 0;

        // Reset state
        step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        check("reset_digits", 32'(disp()), 32'h0);
        check("reset_zero", 32'(bus.zero), 32'd1);
        check("reset_done", 32'(bus.done), 32'd0);

        // Entry, long hold, invalid digit
        press(4'd1, 5, 1'b0); press(4'd2, 5, 1'b0); press(4'd3, 5, 1'b0); press(4'd0, 5, 1'b0);
        check("entry_1230", 32'(disp()), 32'h1230);
        press(4'd7, 20, 1'b0);
        check("hold_once", 32'(disp()), 32'h2307);
        press(4'hA, 5, 1'b0);
        check("invalid_digit", 32'(disp()), 32'h2307);
        press(4'd4, 4, 1'b1);
        check("load_while_counting", 32'(disp()), 32'h2307);

        // Countdown
        load4(4'd0, 4'd1, 4'd0, 4'd0);
        check("load_0100", 32'(disp()), 32'h0100);
        tick(1'b1);
        check("tick_0059", 32'(disp()), 32'h0059);
        tick(1'b1); tick(1'b1);
        check("tick_0057", 32'(disp()), 32'h0057);
        tick(1'b0);
        check("paused_hold", 32'(disp()), 32'h0057);

        // Borrow chain and unnormalised seconds tens
        load4(4'd1, 4'd0, 4'd0, 4'd0);
        tick(1'b1);
        check("borrow_0959", 32'(disp()), 32'h0959);
        load4(4'd0, 4'd0, 4'd1, 4'd0);
        tick(1'b1);
        check("borrow_0009", 32'(disp()), 32'h0009);
        load4(4'd0, 4'd0, 4'd7, 4'd5);
        tick(1'b1);
        check("no_norm_0074", 32'(disp()), 32'h0074);

        // Reaching zero and holding there
        load4(4'd0, 4'd0, 4'd0, 4'd2);
        done_seen = 0;
        tick(1'b1);
        check("zero_0001", 32'(disp()), 32'h0001);
        tick(1'b1);
        check("zero_0000", 32'(disp()), 32'h0000);
        tick(1'b1);
        check("zero_hold", 32'(disp()), 32'h0000);
        check("zero_flag", 32'(bus.zero), 32'd1);
`ifdef DONE_PULSE_EN
        check("done_pulses", 32'(done_seen), 32'd1);
`else
        check("done_pulses", 32'(done_seen), 32'd0);
`endif

        // Loading zeros raises no done
        done_seen = 0;
        load4(4'd0, 4'd0, 4'd0, 4'd0);
        check("load_zero_done", 32'(done_seen), 32'd0);

        // Simultaneous load and tick edges
        load4(4'd0, 4'd0, 4'd3, 4'd0);
        step(1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
        check("collide_shift", 32'(disp()), 32'h0306);
        step(1'b0, 1'b0, 4'd8, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'd8, 1'b0, 1'b1);
        check("collide_tick", 32'(disp()), 32'h0305);

        // Reset mid-countdown
        load4(4'd0, 4'd5, 4'd1, 4'd8);
        tick(1'b1);
        check("pre_reset_0517", 32'(disp()), 32'h0517);
        done_seen = 0;
        step(1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
        check("mid_reset_digits", 32'(disp()), 32'h0);
        step(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        check("mid_reset_done", 32'(done_seen), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
